// File: rtl/exc_commit_arbiter.sv
// rtl/exc_commit_arbiter.sv - oldest-lane exception commit: CP0 update, timed flush, PC redirect
// Optional perf counters built only when EXC_CTRL_PERF_CNT_EN is defined.
module exc_commit_arbiter #(
  parameter int          NUM_LANES    = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_LANES-1:0]   lane_valid,
  input  logic [32*NUM_LANES-1:0] lane_pc,
  input  logic [32*NUM_LANES-1:0] lane_badvaddr,
  input  logic [NUM_LANES-1:0]   lane_bd,
  input  logic [9*NUM_LANES-1:0] lane_exc,
  input  logic [31:0]            r_cp0_epc,
  input  logic                   redirect_ready,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic                   w_cp0_update_ena,
  output logic [4:0]             w_cp0_exccode,
  output logic                   w_cp0_bd,
  output logic                   w_cp0_exl,
  output logic [31:0]            w_cp0_epc,
  output logic                   w_cp0_badvaddr_ena,
  output logic [31:0]            w_cp0_badvaddr,
  output logic                   cp0_cls_exl,
  output logic                   flush_pipline,
  output logic [NUM_LANES-1:0]   lane_kill,
  output logic                   exc_busy,
  output logic [CNT_W-1:0]       perf_exc_cnt,
  output logic [CNT_W-1:0]       perf_eret_cnt
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic                 first;
  logic                 cap_eret;
  logic [31:0]          cap_ret_pc;
  logic [NUM_LANES-1:0] cap_mask;

  logic                 win_found;
  logic [8:0]           win_exc;
  logic [31:0]          win_pc;
  logic [31:0]          win_bva;
  logic                 win_bd;
  logic [NUM_LANES-1:0] win_mask;
  logic [4:0]           win_code;
  logic                 win_eret;
  logic                 win_bva_ena;
  logic [31:0]          win_bva_val;

  // Scan youngest to oldest so the oldest excepting lane overwrites last.
  always_comb begin
    win_found = 1'b0;
    win_exc   = '0;
    win_pc    = '0;
    win_bva   = '0;
    win_bd    = 1'b0;
    win_mask  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_valid[i] && (lane_exc[9*i +: 9] != 9'd0)) begin
        win_found = 1'b1;
        win_exc   = lane_exc[9*i +: 9];
        win_pc    = lane_pc[32*i +: 32];
        win_bva   = lane_badvaddr[32*i +: 32];
        win_bd    = lane_bd[i];
        win_mask  = {NUM_LANES{1'b1}} << i;
      end
    end
  end

  // Flag bit order already matches in-lane priority: lowest set bit wins.
  always_comb begin
    win_code    = 5'h00;
    win_eret    = 1'b0;
    win_bva_ena = 1'b0;
    win_bva_val = '0;
    if (win_exc[0]) begin
      win_code = 5'h00;
    end else if (win_exc[1]) begin
      win_code    = 5'h04;
      win_bva_ena = 1'b1;
      win_bva_val = win_pc;
    end else if (win_exc[2]) begin
      win_code = 5'h0a;
    end else if (win_exc[3]) begin
      win_code = 5'h0c;
    end else if (win_exc[4]) begin
      win_code = 5'h08;
    end else if (win_exc[5]) begin
      win_code = 5'h09;
    end else if (win_exc[6]) begin
      win_eret = 1'b1;
    end else if (win_exc[7]) begin
      win_code    = 5'h04;
      win_bva_ena = 1'b1;
      win_bva_val = win_bva;
    end else if (win_exc[8]) begin
      win_code    = 5'h05;
      win_bva_ena = 1'b1;
      win_bva_val = win_bva;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (win_found) state_nxt = FLUSH;
      FLUSH:    if (cnt == '0) state_nxt = REDIRECT;
      REDIRECT: if (redirect_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cp0_update_ena = 1'b0;
    cp0_cls_exl      = 1'b0;
    flush_pipline    = 1'b0;
    lane_kill        = '0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    exc_busy         = 1'b0;
    case (state)
      FLUSH: begin
        exc_busy         = 1'b1;
        flush_pipline    = 1'b1;
        lane_kill        = cap_mask;
        w_cp0_update_ena = first & ~cap_eret;
        cp0_cls_exl      = first & cap_eret;
      end
      REDIRECT: begin
        exc_busy       = 1'b1;
        flush_pipline  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = cap_eret ? cap_ret_pc : EXC_VECTOR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first              <= 1'b0;
      cnt                <= '0;
      cap_eret           <= 1'b0;
      cap_ret_pc         <= '0;
      cap_mask           <= '0;
      w_cp0_exccode      <= '0;
      w_cp0_bd           <= 1'b0;
      w_cp0_exl          <= 1'b0;
      w_cp0_epc          <= '0;
      w_cp0_badvaddr_ena <= 1'b0;
      w_cp0_badvaddr     <= '0;
    end else begin
      first <= 1'b0;
      if (state == IDLE && win_found) begin
        first              <= 1'b1;
        cnt                <= CW'(FLUSH_CYCLES - 1);
        cap_eret           <= win_eret;
        cap_ret_pc         <= r_cp0_epc;
        cap_mask           <= win_mask;
        w_cp0_exccode      <= win_code;
        w_cp0_bd           <= win_bd;
        w_cp0_exl          <= ~win_eret;
        w_cp0_epc          <= win_bd ? (win_pc - 32'd4) : win_pc;
        w_cp0_badvaddr_ena <= win_bva_ena;
        w_cp0_badvaddr     <= win_bva_val;
      end else if (state == FLUSH && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

`ifdef EXC_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_exc_cnt  <= '0;
      perf_eret_cnt <= '0;
    end else begin
      if (w_cp0_update_ena && (perf_exc_cnt != '1))
        perf_exc_cnt <= perf_exc_cnt + CNT_W'(1);
      if (cp0_cls_exl && (perf_eret_cnt != '1))
        perf_eret_cnt <= perf_eret_cnt + CNT_W'(1);
    end
  end
`else
  assign perf_exc_cnt  = '0;
  assign perf_eret_cnt = '0;
`endif

endmodule

// File: tb/tb_exc_commit_arbiter.sv
// tb/tb_exc_commit_arbiter.sv - directed table-driven bench for exc_commit_arbiter
// Perf count expectations follow EXC_CTRL_PERF_CNT_EN.
module tb_exc_commit_arbiter;

  localparam int          FC  = 3;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  lane_valid = '0;
  logic [63:0] lane_pc = '0;
  logic [63:0] lane_badvaddr = '0;
  logic [1:0]  lane_bd = '0;
  logic [17:0] lane_exc = '0;
  logic [31:0] r_cp0_epc = '0;
  logic        redirect_ready = 1'b1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        w_cp0_update_ena;
  logic [4:0]  w_cp0_exccode;
  logic        w_cp0_bd;
  logic        w_cp0_exl;
  logic [31:0] w_cp0_epc;
  logic        w_cp0_badvaddr_ena;
  logic [31:0] w_cp0_badvaddr;
  logic        cp0_cls_exl;
  logic        flush_pipline;
  logic [1:0]  lane_kill;
  logic        exc_busy;
  logic [31:0] perf_exc_cnt;
  logic [31:0] perf_eret_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  exc_commit_arbiter #(
    .NUM_LANES(2), .EXC_VECTOR(VEC), .FLUSH_CYCLES(FC), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .lane_valid(lane_valid), .lane_pc(lane_pc),
    .lane_badvaddr(lane_badvaddr), .lane_bd(lane_bd), .lane_exc(lane_exc),
    .r_cp0_epc(r_cp0_epc), .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .w_cp0_update_ena(w_cp0_update_ena), .w_cp0_exccode(w_cp0_exccode),
    .w_cp0_bd(w_cp0_bd), .w_cp0_exl(w_cp0_exl), .w_cp0_epc(w_cp0_epc),
    .w_cp0_badvaddr_ena(w_cp0_badvaddr_ena), .w_cp0_badvaddr(w_cp0_badvaddr),
    .cp0_cls_exl(cp0_cls_exl), .flush_pipline(flush_pipline), .lane_kill(lane_kill),
    .exc_busy(exc_busy), .perf_exc_cnt(perf_exc_cnt), .perf_eret_cnt(perf_eret_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] pc0, pc1, bva0, bva1;
    logic [1:0]  bd;
    logic [8:0]  exc0, exc1;
    logic [31:0] epc_in;
    logic        eret;
    logic [4:0]  code;
    logic        exp_bd;
    logic [31:0] epc;
    logic        bva_ena;
    logic [31:0] bva;
    logic [1:0]  kill;
    logic [31:0] rpc;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    lane_valid = '0;
    lane_exc   = '0;
    lane_bd    = '0;
    r_cp0_epc  = 32'h5555_5555;
  endtask

  task automatic drive_vec(input int k);
    lane_valid    = vt[k].valid;
    lane_pc       = {vt[k].pc1, vt[k].pc0};
    lane_badvaddr = {vt[k].bva1, vt[k].bva0};
    lane_bd       = vt[k].bd;
    lane_exc      = {vt[k].exc1, vt[k].exc0};
    r_cp0_epc     = vt[k].epc_in;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = vt[k];
    @(negedge clk);
    drive_vec(k);
    @(negedge clk);
    idle_inputs();
    chk("upd_ena", w_cp0_update_ena, !v.eret);
    chk("cls_exl", cp0_cls_exl, v.eret);
    chk("kill", lane_kill, v.kill);
    chk("flush", flush_pipline, 1'b1);
    if (!v.eret) begin
      chk("exccode", w_cp0_exccode, v.code);
      chk("bd", w_cp0_bd, v.exp_bd);
      chk("epc", w_cp0_epc, v.epc);
      chk("exl", w_cp0_exl, 1'b1);
      chk("bva_ena", w_cp0_badvaddr_ena, v.bva_ena);
      if (v.bva_ena) chk("bva", w_cp0_badvaddr, v.bva);
    end
    repeat (FC - 1) begin
      @(negedge clk);
      chk("strobe_once", w_cp0_update_ena | cp0_cls_exl, 1'b0);
      chk("kill_hold", lane_kill, v.kill);
      chk("no_redirect_in_flush", redirect_valid, 1'b0);
    end
    @(negedge clk);
    chk("rv", redirect_valid, 1'b1);
    chk("rpc", redirect_pc, v.rpc);
    chk("kill_redir", lane_kill, 2'b00);
    chk("flush_redir", flush_pipline, 1'b1);
    @(negedge clk);
    chk("busy_idle", exc_busy, 1'b0);
    chk("flush_idle", flush_pipline, 1'b0);
    chk("rv_idle", redirect_valid, 1'b0);
  endtask

  int flush_cnt;
  int strobe_cnt;
  logic [31:0] exp_exc_cnt;
  logic [31:0] exp_eret_cnt;

  initial begin
    vt[0] = '{2'b01, 32'hBFC0_0100, 32'h0, 32'h0, 32'h0, 2'b00, 9'h004, 9'h000, 32'h0,
              1'b0, 5'h0a, 1'b0, 32'hBFC0_0100, 1'b0, 32'h0, 2'b11, VEC};
    vt[1] = '{2'b11, 32'h8000_0000, 32'h8000_0010, 32'h0, 32'h8000_0003, 2'b10, 9'h000, 9'h100, 32'h0,
              1'b0, 5'h05, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0003, 2'b10, VEC};
    vt[2] = '{2'b11, 32'h0040_0000, 32'h0040_0004, 32'h0, 32'h0, 2'b00, 9'h011, 9'h008, 32'h0,
              1'b0, 5'h00, 1'b0, 32'h0040_0000, 1'b0, 32'h0, 2'b11, VEC};
    vt[3] = '{2'b10, 32'h0000_1000, 32'h1234_5679, 32'h0, 32'h0, 2'b01, 9'h001, 9'h002, 32'h0,
              1'b0, 5'h04, 1'b0, 32'h1234_5679, 1'b1, 32'h1234_5679, 2'b10, VEC};
    vt[4] = '{2'b01, 32'h8000_0100, 32'h0, 32'h0, 32'h0, 2'b00, 9'h040, 9'h000, 32'h8000_2000,
              1'b1, 5'h00, 1'b0, 32'h0, 1'b0, 32'h0, 2'b11, 32'h8000_2000};
    vt[5] = '{2'b01, 32'h8000_0004, 32'h0, 32'h0, 32'h0, 2'b01, 9'h0A0, 9'h000, 32'h0,
              1'b0, 5'h09, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 2'b11, VEC};
    vt[6] = '{2'b10, 32'h0, 32'h0000_0000, 32'h0, 32'hDEAD_BEE0, 2'b10, 9'h000, 9'h080, 32'h0,
              1'b0, 5'h04, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hDEAD_BEE0, 2'b10, VEC};
    vt[7] = '{2'b11, 32'h0000_0100, 32'h2000_0008, 32'h0, 32'h0, 2'b00, 9'h000, 9'h048, 32'h0,
              1'b0, 5'h0c, 1'b0, 32'h2000_0008, 1'b0, 32'h0, 2'b10, VEC};

    // reset state, with an exception pending on the inputs
    drive_vec(0);
    repeat (2) @(negedge clk);
    chk("rst_busy", exc_busy, 1'b0);
    chk("rst_flush", flush_pipline, 1'b0);
    chk("rst_upd", w_cp0_update_ena, 1'b0);
    chk("rst_epc", w_cp0_epc, 32'h0);
    chk("rst_rv", redirect_valid, 1'b0);
    chk("rst_perf", perf_exc_cnt | perf_eret_cnt, 32'h0);
    idle_inputs();
    rst = 1'b1;

    for (int k = 0; k < 8; k++) run_vec(k);

    // ERET with redirect back-pressure; EPC must be the captured value
    redirect_ready = 1'b0;
    @(negedge clk);
    drive_vec(4);
    @(negedge clk);
    idle_inputs();
    r_cp0_epc = 32'h1111_2222;
    chk("eret_cls", cp0_cls_exl, 1'b1);
    chk("eret_upd", w_cp0_update_ena, 1'b0);
    repeat (FC - 1) @(negedge clk);
    chk("eret_cls_pulse", cp0_cls_exl, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("eret_rv_hold", redirect_valid, 1'b1);
      chk("eret_rpc_hold", redirect_pc, 32'h8000_2000);
      if (c == 3) redirect_ready = 1'b1;
    end
    @(negedge clk);
    chk("eret_idle", exc_busy, 1'b0);

    // new exceptions during FLUSH/REDIRECT are ignored
    flush_cnt  = 0;
    strobe_cnt = 0;
    @(negedge clk);
    drive_vec(0);
    for (int c = 1; c <= FC + 1; c++) begin
      @(negedge clk);
      flush_cnt  += int'(flush_pipline);
      strobe_cnt += int'(w_cp0_update_ena);
      if (c == 1) begin
        lane_valid = 2'b11;
        lane_exc   = {9'h008, 9'h000};
      end
      if (c == FC + 1) idle_inputs();
    end
    @(negedge clk);
    chk("ign_busy", exc_busy, 1'b0);
    @(negedge clk);
    flush_cnt  += int'(flush_pipline);
    strobe_cnt += int'(w_cp0_update_ena);
    chk("ign_flush_cycles", flush_cnt, FC + 1);
    chk("ign_strobes", strobe_cnt, 1);
    chk("ign_code", w_cp0_exccode, 5'h0a);

    // asynchronous reset in FLUSH aborts the sequence
    @(negedge clk);
    drive_vec(1);
    @(negedge clk);
    idle_inputs();
    #1 rst = 1'b0;
    #1;
    chk("abort_flush", flush_pipline, 1'b0);
    chk("abort_kill", lane_kill, 2'b00);
    chk("abort_busy", exc_busy, 1'b0);
    chk("abort_code", w_cp0_exccode, 5'h00);
    chk("abort_bva", w_cp0_badvaddr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    strobe_cnt = 0;
    repeat (FC + 2) begin
      @(negedge clk);
      strobe_cnt += int'(redirect_valid) + int'(w_cp0_update_ena);
    end
    chk("abort_no_redirect", strobe_cnt, 0);

    // perf counters: 5 exceptions + 2 ERETs
    for (int k = 0; k < 5; k++) run_vec(0);
    for (int k = 0; k < 2; k++) run_vec(4);
`ifdef EXC_CTRL_PERF_CNT_EN
    exp_exc_cnt  = 32'd5;
    exp_eret_cnt = 32'd2;
`else
    exp_exc_cnt  = 32'd0;
    exp_eret_cnt = 32'd0;
`endif
    chk("perf_exc", perf_exc_cnt, exp_exc_cnt);
    chk("perf_eret", perf_eret_cnt, exp_eret_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
